mod_counter: RTL and testbench

Parametrised modulo up/down counter with synchronous clear, parallel load, optional input edge detection and a wrap/terminal-count pulse. It generalises the plain free-running counter and the rising-edge detector into one block. Intended uses are frame/pixel position counters, SPI bit counters and event tallies. Single clock domain; all state updates on posedge clock.

---
 rtl/mod_counter.sv | 105 ++++++++++
 tb/tb_mod_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Modulo up/down counter with synchronous clear, clamped parallel load, optional edge-triggered steps and a wrap pulse.
// Optional macro MOD_COUNTER_SAT_EN: saturate at 0 / MODULUS-1 instead of wrapping (wrap flags the rejected step).
module mod_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MODULUS   = 256,
    parameter int unsigned EDGE_MODE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);

    generate
        if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
            $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    logic up_req;
    logic down_req;

    // Edge history samples every cycle, so a level held through reset, clear or load never counts.
    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic prev_up;
            logic prev_down;

            always_ff @(posedge clock) begin
                prev_up   <= up;
                prev_down <= down;
            end

            assign up_req   = up & ~prev_up;
            assign down_req = down & ~prev_down;
        end else begin : g_level
            assign up_req   = up;
            assign down_req = down;
        end
    endgenerate

    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;

    always_comb begin
        inc        = up_req & ~down_req;
        dec        = down_req & ~up_req;
        count_next = count;
        wrap_next  = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            // Widened compare keeps the clamp meaningful when MODULUS == 2**WIDTH.
            count_next = ({1'b0, load_value} > MAX_EXT) ? MAX : load_value;
        end else if (inc) begin
            if (count == MAX) begin
`ifdef MOD_COUNTER_SAT_EN
                count_next = MAX;
`else
                count_next = '0;
`endif
                wrap_next  = 1'b1;
            end else begin
                count_next = count + WIDTH'(1);
            end
        end else if (dec) begin
            if (count == '0) begin
`ifdef MOD_COUNTER_SAT_EN
                count_next = '0;
`else
                count_next = MAX;
`endif
                wrap_next  = 1'b1;
            end else begin
                count_next = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

    assign at_zero = (count == '0);
    assign at_max  = (count == MAX);

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: three instances (mod-10 level, mod-10 edge, mod-256 level).
// Expectations follow MOD_COUNTER_SAT_EN when the macro is defined for the build.
module tb_mod_counter;

`ifdef MOD_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_s [3];
    logic       clear_s [3];
    logic       load_s  [3];
    logic       up_s    [3];
    logic       down_s  [3];
    logic [7:0] lv_s    [3];
    logic       at_zero_s [3];
    logic       at_max_s  [3];
    logic       wrap_s    [3];
    logic [3:0] count_a;
    logic [3:0] count_b;
    logic [7:0] count_c;

    mod_counter #(.WIDTH(4), .MODULUS(10), .EDGE_MODE(0)) u_a (
        .clock(clock), .reset(reset_s[0]), .clear(clear_s[0]), .load(load_s[0]),
        .load_value(lv_s[0][3:0]), .up(up_s[0]), .down(down_s[0]),
        .count(count_a), .at_zero(at_zero_s[0]), .at_max(at_max_s[0]), .wrap(wrap_s[0])
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .EDGE_MODE(1)) u_b (
        .clock(clock), .reset(reset_s[1]), .clear(clear_s[1]), .load(load_s[1]),
        .load_value(lv_s[1][3:0]), .up(up_s[1]), .down(down_s[1]),
        .count(count_b), .at_zero(at_zero_s[1]), .at_max(at_max_s[1]), .wrap(wrap_s[1])
    );

    mod_counter #(.WIDTH(8), .MODULUS(256), .EDGE_MODE(0)) u_c (
        .clock(clock), .reset(reset_s[2]), .clear(clear_s[2]), .load(load_s[2]),
        .load_value(lv_s[2]), .up(up_s[2]), .down(down_s[2]),
        .count(count_c), .at_zero(at_zero_s[2]), .at_max(at_max_s[2]), .wrap(wrap_s[2])
    );

    typedef struct {
        logic       reset;
        logic       clear;
        logic       load;
        logic [7:0] lv;
        logic       up;
        logic       down;
        int         exp_count;
        logic       exp_wrap;
    } vec_t;

    typedef struct {
        int    id;
        int    exp_count;
        logic  exp_wrap;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(input logic rst, input logic clr, input logic ld, input int lv,
                                input logic u, input logic d, input int c, input logic w);
        vec_t v;
        v.reset = rst; v.clear = clr; v.load = ld; v.lv = 8'(lv);
        v.up = u; v.down = d; v.exp_count = c; v.exp_wrap = w;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_out();
        exp_t e;
        int   act;
        int   maxv;
        e = sbq.pop_front();
        case (e.id)
            0:       act = int'(count_a);
            1:       act = int'(count_b);
            default: act = int'(count_c);
        endcase
        maxv = (e.id == 2) ? 255 : 9;
        cmp({e.tag, " count"},   act,                    e.exp_count);
        cmp({e.tag, " wrap"},    int'(wrap_s[e.id]),     int'(e.exp_wrap));
        cmp({e.tag, " at_zero"}, int'(at_zero_s[e.id]),  (e.exp_count == 0) ? 1 : 0);
        cmp({e.tag, " at_max"},  int'(at_max_s[e.id]),   (e.exp_count == maxv) ? 1 : 0);
    endtask

    task automatic step(input int id, input vec_t v, input string tag);
        exp_t e;
        reset_s[id] = v.reset;
        clear_s[id] = v.clear;
        load_s[id]  = v.load;
        lv_s[id]    = v.lv;
        up_s[id]    = v.up;
        down_s[id]  = v.down;
        e.id = id; e.exp_count = v.exp_count; e.exp_wrap = v.exp_wrap; e.tag = tag;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        check_out();
    endtask

    vec_t tbl_a[$];
    vec_t seq_b[$];

    initial begin
        int wraps;
        for (int k = 0; k < 3; k++) begin
            reset_s[k] = 1'b0; clear_s[k] = 1'b0; load_s[k] = 1'b0;
            up_s[k] = 1'b0; down_s[k] = 1'b0; lv_s[k] = 8'd0;
        end

        // Mod-10 level-mode table: counting, wrap, clamp, priority, hold.
        tbl_a.push_back(mk(1,0,0, 0,0,0, 0,0));
        for (int i = 1; i <= 9; i++) tbl_a.push_back(mk(0,0,0, 0,1,0, i,0));
        tbl_a.push_back(mk(0,0,0, 0,1,0, SAT ? 9 : 0, 1));
        tbl_a.push_back(mk(0,0,0, 0,1,0, SAT ? 9 : 1, SAT));
        tbl_a.push_back(mk(0,0,0, 0,1,0, SAT ? 9 : 2, SAT));
        tbl_a.push_back(mk(0,0,1,13,0,0, 9,0));
        tbl_a.push_back(mk(0,1,1, 5,0,0, 0,0));
        tbl_a.push_back(mk(0,0,1, 6,0,0, 6,0));
        tbl_a.push_back(mk(0,0,0, 0,1,0, 7,0));
        tbl_a.push_back(mk(1,0,0, 0,1,0, 0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,1, SAT ? 0 : 9, 1));
        tbl_a.push_back(mk(0,0,0, 0,1,1, SAT ? 0 : 9, 0));
        tbl_a.push_back(mk(0,0,0, 0,0,0, SAT ? 0 : 9, 0));
        tbl_a.push_back(mk(0,0,1, 9,0,0, 9,0));
        tbl_a.push_back(mk(0,0,0, 0,1,0, SAT ? 9 : 0, 1));
        tbl_a.push_back(mk(0,0,1,10,0,0, 9,0));
        tbl_a.push_back(mk(0,0,1,15,0,0, 9,0));
        tbl_a.push_back(mk(0,0,1, 3,1,0, 3,0));
        tbl_a.push_back(mk(0,0,1, 4,0,1, 4,0));
        tbl_a.push_back(mk(0,0,0, 0,0,1, 3,0));
        tbl_a.push_back(mk(0,0,0, 0,0,1, 2,0));
        tbl_a.push_back(mk(0,1,0, 0,0,1, 0,0));
        tbl_a.push_back(mk(0,0,0, 0,0,1, SAT ? 0 : 9, 1));
        tbl_a.push_back(mk(0,0,0, 0,0,1, SAT ? 0 : 8, SAT));
        foreach (tbl_a[i]) step(0, tbl_a[i], $sformatf("a[%0d]", i));

        // Edge mode: held level through reset, single pulses, edges swallowed by load/clear.
        seq_b.push_back(mk(1,0,0, 0,1,0, 0,0));
        seq_b.push_back(mk(1,0,0, 0,1,0, 0,0));
        for (int i = 0; i < 5; i++) seq_b.push_back(mk(0,0,0, 0,1,0, 0,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 0,0));
        seq_b.push_back(mk(0,0,0, 0,1,0, 1,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 1,0));
        seq_b.push_back(mk(0,0,0, 0,1,0, 2,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 2,0));
        seq_b.push_back(mk(0,0,0, 0,1,0, 3,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 3,0));
        seq_b.push_back(mk(0,0,1, 6,1,0, 6,0));
        seq_b.push_back(mk(0,0,0, 0,1,0, 6,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 6,0));
        seq_b.push_back(mk(0,0,0, 0,0,1, 5,0));
        seq_b.push_back(mk(0,0,0, 0,0,1, 5,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 5,0));
        seq_b.push_back(mk(0,1,0, 0,1,0, 0,0));
        seq_b.push_back(mk(0,0,0, 0,1,0, 0,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 0,0));
        seq_b.push_back(mk(0,0,0, 0,1,0, 1,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 1,0));
        seq_b.push_back(mk(0,0,0, 0,1,1, 1,0));
        seq_b.push_back(mk(0,0,0, 0,0,0, 1,0));
        seq_b.push_back(mk(0,1,0, 0,0,0, 0,0));
        seq_b.push_back(mk(0,0,0, 0,0,1, SAT ? 0 : 9, 1));
        seq_b.push_back(mk(0,0,0, 0,0,1, SAT ? 0 : 9, 0));
        foreach (seq_b[i]) step(1, seq_b[i], $sformatf("b[%0d]", i));

        // Full-range mod-256: one wrap per lap, then underflow from 0.
        step(2, mk(1,0,0, 0,0,0, 0,0), "c reset");
        wraps = 0;
        for (int i = 0; i < 256; i++) begin
            step(2, mk(0,0,0, 0,1,0, SAT ? ((i == 255) ? 255 : i + 1) : (i + 1) % 256, (i == 255)),
                 $sformatf("c up[%0d]", i));
            if (wrap_s[2]) wraps++;
        end
        cmp("c wrap pulses", wraps, 1);
        step(2, mk(0,0,0, 0,0,1, SAT ? 254 : 255, !SAT), "c down");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
